mc_datapath_gen: RTL and testbench

MC_DATAPATH_GEN -- requirements
Module: mc_datapath_gen

---
 rtl/mc_datapath_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_mc_datapath_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_gen.sv
// Multicycle RV32 datapath with a two-state memory handshake unit.
//
// The controller drives the strobes and selects. This block holds the
// architectural and temporary registers, the register file, the immediate
// generator, the ALU, load extension and store-lane formatting. It talks to
// memory through a req/ready channel that stalls the datapath for the whole
// transaction.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   RegWrite .. MemWrite controller strobes (MemReq starts a memory access)
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl   controller selects
//   mem_req/we/addr/wdata/wstrb   request channel, held stable while busy
//   mem_rdata, mem_ready          response channel
//   PC, Result, op, func3, func7b5, Zero   decode/status back to controller
//   Stall        datapath frozen for a memory access
//   MisalignErr  one-cycle pulse for a rejected misaligned access
//
// Memory FSM
//   state  | meaning
//   S_IDLE | no transaction; MemReq with an aligned address issues one
//   S_BUSY | mem_req asserted, request held, waiting for mem_ready
module mc_datapath_gen #(
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        AdrSrc,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [1:0]  ResultSrc,
    input  logic [1:0]  ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [2:0]  ImmSrc,
    input  logic [3:0]  ALUControl,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic [31:0] Result,
    output logic [6:0]  op,
    output logic [2:0]  func3,
    output logic        func7b5,
    output logic        Zero,
    output logic        Stall,
    output logic        MisalignErr
);

    localparam int AW = $clog2(NREG);

    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t state_q, state_d;

    logic [31:0] old_pc, ir, data_q, a_q, wd_q, alu_out, mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        mem_we_q;

    logic [31:0] rf [NREG];
    logic [31:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, load_data, adr;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [1:0]  acc_size;
    logic        misalign, issue, accept;

    assign op      = ir[6:0];
    assign func3   = ir[14:12];
    assign func7b5 = ir[30];

    function automatic logic in_range(input logic [4:0] idx);
        return (idx != 5'd0) && ({27'd0, idx} < 32'(NREG));
    endfunction

    // Register file: x0 and indices beyond the implemented depth read as zero.
    assign rd1 = in_range(ir[19:15]) ? rf[ir[15+AW-1:15]] : 32'd0;
    assign rd2 = in_range(ir[24:20]) ? rf[ir[20+AW-1:20]] : 32'd0;

    always_ff @(posedge clk) begin
        if (RegWrite && !Stall && in_range(ir[11:7]))
            rf[ir[7+AW-1:7]] <= Result;
    end

    always_comb begin
        imm_ext = 32'd0;
        case (ImmSrc)
            3'd0: imm_ext = {{20{ir[31]}}, ir[31:20]};
            3'd1: imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            3'd2: imm_ext = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            3'd3: imm_ext = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            3'd4: imm_ext = {ir[31:12], 12'd0};
            default: imm_ext = 32'd0;
        endcase
    end

    always_comb begin
        src_a = 32'd0;
        case (ALUSrcA)
            2'd0: src_a = PC;
            2'd1: src_a = old_pc;
            2'd2: src_a = a_q;
            default: src_a = 32'd0;
        endcase
        src_b = 32'd0;
        case (ALUSrcB)
            2'd0: src_b = wd_q;
            2'd1: src_b = imm_ext;
            2'd2: src_b = 32'd4;
            default: src_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (ALUControl)
            4'd0: alu_result = src_a + src_b;
            4'd1: alu_result = src_a - src_b;
            4'd2: alu_result = src_a & src_b;
            4'd3: alu_result = src_a | src_b;
            4'd4: alu_result = src_a ^ src_b;
            4'd5: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            4'd6: alu_result = {31'd0, src_a < src_b};
            4'd7: alu_result = src_a << src_b[4:0];
            4'd8: alu_result = src_a >> src_b[4:0];
            4'd9: alu_result = $signed(src_a) >>> src_b[4:0];
            default: alu_result = 32'd0;
        endcase
    end

    assign Zero = (alu_result == 32'd0);

    // Load extension uses the address of the transaction that filled Data.
    logic [31:0] ld_shift;
    logic [15:0] ld_half;
    assign ld_shift = data_q >> {mem_addr_q[1:0], 3'b000};
    assign ld_half  = mem_addr_q[1] ? data_q[31:16] : data_q[15:0];

    always_comb begin
        load_data = data_q;
        case (ir[14:12])
            3'b000: load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001: load_data = {{16{ld_half[15]}}, ld_half};
            3'b100: load_data = {24'd0, ld_shift[7:0]};
            3'b101: load_data = {16'd0, ld_half};
            default: load_data = data_q;
        endcase
    end

    always_comb begin
        Result = alu_out;
        case (ResultSrc)
            2'd0: Result = alu_out;
            2'd1: Result = load_data;
            2'd2: Result = alu_result;
            default: Result = imm_ext;
        endcase
    end

    // Instruction fetches (AdrSrc=0) are always full-word; func3[1:0] sizes
    // data accesses, with 2'b11 treated as a word.
    assign adr      = AdrSrc ? Result : PC;
    assign acc_size = AdrSrc ? ir[13:12] : 2'b10;
    assign misalign = ((acc_size == 2'b01) && adr[0]) ||
                      (acc_size[1] && (adr[1:0] != 2'b00));

    always_comb begin
        st_strb = 4'b1111;
        st_data = wd_q;
        case (acc_size)
            2'b00: begin
                st_strb = 4'b0001 << adr[1:0];
                st_data = {4{wd_q[7:0]}};
            end
            2'b01: begin
                st_strb = adr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wd_q[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wd_q;
            end
        endcase
    end

    assign issue  = (state_q == S_IDLE) && MemReq && !misalign;
    assign accept = (state_q == S_BUSY) && mem_ready;

    // Gated by reset so an asserted MemReq cannot leak through while in reset.
    assign Stall       = reset && (issue || ((state_q == S_BUSY) && !mem_ready));
    assign MisalignErr = reset && (state_q == S_IDLE) && MemReq && misalign;

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        case (state_q)
            S_IDLE: if (issue) state_d = S_BUSY;
            S_BUSY: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            PC          <= RESET_PC;
            old_pc      <= 32'd0;
            ir          <= 32'h0000_0013;
            data_q      <= 32'd0;
            a_q         <= 32'd0;
            wd_q        <= 32'd0;
            alu_out     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
        end else begin
            state_q <= state_d;
            // The request is captured in the issue cycle, which is itself a
            // stall cycle, so it is held for the rest of the transaction.
            if (issue) begin
                mem_addr_q  <= adr;
                mem_we_q    <= MemWrite;
                mem_wdata_q <= st_data;
                mem_wstrb_q <= MemWrite ? st_strb : 4'd0;
            end
            if (!Stall) begin
                if (PCWrite) PC <= Result;
                if (IRWrite && accept) begin
                    old_pc <= PC;
                    ir     <= mem_rdata;
                end
                if (accept && !mem_we_q) data_q <= mem_rdata;
                a_q     <= rd1;
                wd_q    <= rd2;
                alu_out <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_mc_datapath_gen.sv
module tb_mc_datapath_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite, IRWrite, PCWrite, AdrSrc, MemReq, MemWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] PC, Result;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic        func7b5, Zero, Stall, MisalignErr;

    always #5 clk = ~clk;

    mc_datapath_gen #(.NREG(16), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemReq(MemReq), .MemWrite(MemWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .PC(PC), .Result(Result), .op(op), .func3(func3),
        .func7b5(func7b5), .Zero(Zero), .Stall(Stall), .MisalignErr(MisalignErr)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: observed %h required a queued expectation", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] e);
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_clear();
        RegWrite = 0; IRWrite = 0; PCWrite = 0; AdrSrc = 0; MemReq = 0; MemWrite = 0;
        ResultSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ImmSrc = 0; ALUControl = 0;
    endtask

    // Result := src, selected through the ALU with SrcB = 0.
    task automatic show_src_a(input logic [1:0] sel);
        ALUSrcA = sel; ALUSrcB = 2'd3; ALUControl = 4'd0; ResultSrc = 2'd2;
        #1;
    endtask

    // Fetch cycle: IR <= instr, PC <= PC + 4, with `waits` not-ready cycles.
    task automatic fetch(input logic [31:0] instr, input int waits);
        int stalls;
        stalls = 0;
        ctrl_clear();
        IRWrite = 1; MemReq = 1; PCWrite = 1;
        ALUSrcA = 2'd0; ALUSrcB = 2'd2; ALUControl = 4'd0; ResultSrc = 2'd2;
        sb_push("fetch_addr", exp_pc);
        sb_push("fetch_op", {25'd0, instr[6:0]});
        #1 if (Stall) stalls++;
        tick();
        for (int i = 0; i < waits; i++) begin
            if (Stall) stalls++;
            tick();
        end
        mem_ready = 1; mem_rdata = instr;
        #1;
        sb_check(mem_addr);
        check("fetch_stall_cycles", 32'(stalls), 32'(waits + 1));
        check("fetch_ready_stall", 32'(Stall), 32'd0);
        tick();
        mem_ready = 0; mem_rdata = 32'd0;
        ctrl_clear();
        #1 sb_check(32'(op));
        exp_pc = exp_pc + 32'd4;
        check("fetch_pc", PC, exp_pc);
    endtask

    // Data access; the caller has already set up Result as the address.
    task automatic data_txn(input logic we, input logic [31:0] rdata, input logic [31:0] e_addr,
                            input logic [3:0] e_strb, input logic [31:0] e_wdata);
        AdrSrc = 1; MemReq = 1; MemWrite = we;
        sb_push("data_addr", e_addr);
        sb_push("data_we", 32'(we));
        if (we) begin
            sb_push("data_wstrb", 32'(e_strb));
            sb_push("data_wdata", e_wdata);
        end
        #1 check("data_issue_stall", 32'(Stall), 32'd1);
        tick();
        ImmSrc = 3'd5;  // move Result away; the held request must not follow it
        #1;
        sb_check(mem_addr);
        sb_check(32'(mem_we));
        if (we) begin
            sb_check(32'(mem_wstrb));
            sb_check(mem_wdata);
        end
        check("data_busy_stall", 32'(Stall), 32'd1);
        check("data_busy_req", 32'(mem_req), 32'd1);
        tick();
        mem_ready = 1; mem_rdata = rdata;
        #1 check("data_ready_stall", 32'(Stall), 32'd0);
        tick();
        mem_ready = 0; mem_rdata = 32'd0;
        ctrl_clear();
        #1 check("data_req_drop", 32'(mem_req), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] res;
    } vec_t;

    vec_t alu_pos[$] = '{'{4'd0, 32'd9}, '{4'd1, 32'd1}, '{4'd2, 32'd4}, '{4'd3, 32'd5},
                        '{4'd4, 32'd1}, '{4'd5, 32'd0}, '{4'd6, 32'd0}, '{4'd7, 32'h50},
                        '{4'd8, 32'd0}, '{4'd9, 32'd0}, '{4'd12, 32'd0}};
    vec_t alu_neg[$] = '{'{4'd1, 32'hFFFF_FFF1}, '{4'd5, 32'd1}, '{4'd6, 32'd0},
                        '{4'd8, 32'h0FFF_FFFF}, '{4'd9, 32'hFFFF_FFFF}};
    vec_t imm_tab[$] = '{'{4'd0, 32'hFFFF_FFF0}, '{4'd1, 32'hFFFF_FFE5}, '{4'd2, 32'hFFFF_FFE4},
                        '{4'd3, 32'hFFF0_87F0}, '{4'd4, 32'hFF00_8000}, '{4'd5, 32'd0}};

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; mem_ready = 0; mem_rdata = 32'd0;
        ctrl_clear();
        MemReq = 1;
        tick(); tick();
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_misalign", 32'(MisalignErr), 32'd0);
        ctrl_clear();
        tick();
        reset = 1;
        #1;
        check("rst_pc", PC, 32'd0);
        check("rst_op", 32'(op), 32'h13);
        check("rst_aluout", Result, 32'd0);
        exp_pc = 32'd0;

        // addi x1, x0, 5 with two not-ready cycles
        fetch(32'h0050_0093, 2);
        show_src_a(2'd1);
        check("oldpc_first", Result, 32'd0);
        ResultSrc = 2'd3; ImmSrc = 3'd0; RegWrite = 1;
        #1 check("wb_x1", Result, 32'd5);
        tick(); ctrl_clear();

        // addi x2, x0, 0xAB (minimum-length fetch)
        fetch(32'h0AB0_0113, 0);
        show_src_a(2'd1);
        check("oldpc_second", Result, 32'd4);
        ResultSrc = 2'd3; ImmSrc = 3'd0; RegWrite = 1;
        #1 check("wb_x2", Result, 32'hAB);
        tick(); ctrl_clear();

        // sb x2, 0x102(x0)
        fetch(32'h1020_0123, 1);
        tick();
        ResultSrc = 2'd3; ImmSrc = 3'd1;
        #1 check("store_addr_result", Result, 32'h102);
        data_txn(1'b1, 32'd0, 32'h102, 4'b0100, 32'hABAB_ABAB);

        // lb x3, 0x103(x0)
        fetch(32'h1030_0183, 0);
        ResultSrc = 2'd3; ImmSrc = 3'd0;
        data_txn(1'b0, 32'h80FF_0000, 32'h103, 4'b0000, 32'd0);
        ResultSrc = 2'd1;
        #1 check("lb_signext", Result, 32'hFFFF_FF80);

        // lbu x3, 0x103(x0); first view the fetched word itself through Data
        fetch(32'h1030_4183, 0);
        ResultSrc = 2'd1;
        #1 check("fetch_data_lbu", Result, 32'h0000_0083);
        ResultSrc = 2'd3; ImmSrc = 3'd0;
        data_txn(1'b0, 32'h80FF_0000, 32'h103, 4'b0000, 32'd0);
        ResultSrc = 2'd1;
        #1 check("lbu_zeroext", Result, 32'h0000_0080);

        // lh x3, 0x102(x0)
        fetch(32'h1020_1183, 0);
        ResultSrc = 2'd3; ImmSrc = 3'd0;
        data_txn(1'b0, 32'h80FF_0000, 32'h102, 4'b0000, 32'd0);
        ResultSrc = 2'd1;
        #1 check("lh_signext", Result, 32'hFFFF_80FF);

        // lh x3, 0x101(x0): misaligned, rejected
        fetch(32'h1010_1183, 0);
        ResultSrc = 2'd3; ImmSrc = 3'd0; AdrSrc = 1; MemReq = 1;
        #1;
        check("mis_err", 32'(MisalignErr), 32'd1);
        check("mis_stall", 32'(Stall), 32'd0);
        check("mis_req", 32'(mem_req), 32'd0);
        tick();
        MemReq = 0;
        #1;
        check("mis_err_clear", 32'(MisalignErr), 32'd0);
        check("mis_req_after", 32'(mem_req), 32'd0);
        ctrl_clear();

        // addi x17, x0, 0x55: x17 does not exist with 16 registers
        fetch(32'h0550_0893, 0);
        ResultSrc = 2'd3; ImmSrc = 3'd0; RegWrite = 1;
        #1 check("wb_x17", Result, 32'h55);
        tick(); ctrl_clear();
        fetch(32'h0008_8213, 0);
        tick();
        show_src_a(2'd2);
        check("read_x17", Result, 32'd0);
        check("read_x17_zero", 32'(Zero), 32'd1);

        // addi x4, x1, 0: A = x1 = 5, ALU sweep against constant 4
        fetch(32'h0000_8213, 0);
        tick();
        show_src_a(2'd2);
        check("read_x1", Result, 32'd5);
        ALUSrcB = 2'd2;
        foreach (alu_pos[i]) begin
            ALUControl = alu_pos[i].sel;
            #1;
            check($sformatf("alu_pos_%0d", alu_pos[i].sel), Result, alu_pos[i].res);
            check($sformatf("zero_pos_%0d", alu_pos[i].sel), 32'(Zero),
                  32'(alu_pos[i].res == 32'd0));
        end
        ctrl_clear();

        // addi x5, x1, -16: immediate formats, then x5 = 5 + (-16)
        fetch(32'hFF00_8293, 0);
        tick();
        check("func7b5", 32'(func7b5), 32'd1);
        ResultSrc = 2'd3;
        foreach (imm_tab[i]) begin
            ImmSrc = imm_tab[i].sel[2:0];
            #1 check($sformatf("imm_%0d", imm_tab[i].sel), Result, imm_tab[i].res);
        end
        ALUSrcA = 2'd2; ALUSrcB = 2'd1; ImmSrc = 3'd0; ALUControl = 4'd0;
        ResultSrc = 2'd2; RegWrite = 1;
        #1 check("wb_x5", Result, 32'hFFFF_FFF5);
        tick(); ctrl_clear();

        // addi x6, x5, 0: negative A
        fetch(32'h0002_8313, 0);
        tick();
        show_src_a(2'd2);
        ALUSrcB = 2'd2;
        foreach (alu_neg[i]) begin
            ALUControl = alu_neg[i].sel;
            #1 check($sformatf("alu_neg_%0d", alu_neg[i].sel), Result, alu_neg[i].res);
        end
        ctrl_clear();

        // Reset in the middle of a fetch
        IRWrite = 1; MemReq = 1; PCWrite = 1;
        ALUSrcA = 2'd0; ALUSrcB = 2'd2; ResultSrc = 2'd2;
        tick();
        check("busy_req_before_rst", 32'(mem_req), 32'd1);
        reset = 0;
        #1;
        check("rst_busy_req", 32'(mem_req), 32'd0);
        check("rst_busy_stall", 32'(Stall), 32'd0);
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick(); tick();
        ctrl_clear();
        mem_ready = 0; mem_rdata = 32'd0;
        reset = 1;
        #1;
        check("rst_busy_pc", PC, 32'd0);
        check("rst_busy_op", 32'(op), 32'h13);
        ResultSrc = 2'd1;
        #1 check("rst_busy_data", Result, 32'd0);
        show_src_a(2'd1);
        check("rst_busy_oldpc", Result, 32'd0);
        ctrl_clear();
        tick();

        exp_pc = 32'd0;
        fetch(32'h0050_0093, 0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: observed %0d entries required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
